// File: rtl/ballot_session_ctrl_if.sv
// Voting-terminal bundle between the session controller and its surroundings:
// officer/voter inputs in, counter strobes and panel indications out.
interface ballot_session_ctrl_if;
  logic       mode;
  logic       issue;
  logic [5:0] vote_valid;
  logic [5:0] cand_inc;
  logic       ballot_ready;
  logic       confirm;
  logic       reject;
  logic       timeout;
  logic [7:0] ballots_issued;
  logic [7:0] ballots_cast;
  logic [2:0] scan_sel;
  logic       scan_valid;

  modport master (
    output mode, issue, vote_valid,
    input  cand_inc, ballot_ready, confirm, reject, timeout,
           ballots_issued, ballots_cast, scan_sel, scan_valid
  );

  modport slave (
    input  mode, issue, vote_valid,
    output cand_inc, ballot_ready, confirm, reject, timeout,
           ballots_issued, ballots_cast, scan_sel, scan_valid
  );
endinterface

// File: rtl/ballot_session_ctrl.sv
// Ballot session controller: arms one ballot per officer issue, accepts exactly
// one unambiguous vote, and scans candidate indices for display when closed.
module ballot_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CONFIRM_CYCLES = 10,
  parameter int SCAN_DWELL     = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  ballot_session_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int DW = $clog2(SCAN_DWELL + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CONFIRM, CLOSED} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] conf_cnt_q, conf_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    scan_sel_q, scan_sel_d;
  logic [7:0]    issued_q, issued_d;
  logic [7:0]    cast_q, cast_d;
  logic [5:0]    cand_inc_q, cand_inc_d;
  logic          ballot_ready_q, ballot_ready_d;
  logic          confirm_q, confirm_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic          scan_valid_q, scan_valid_d;

  logic vote_single, vote_multi;

  assign vote_single = $onehot(bus.vote_valid);
  assign vote_multi  = (bus.vote_valid != 6'd0) && !vote_single;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    conf_cnt_d = conf_cnt_q;
    dwell_d    = dwell_q;
    scan_sel_d = scan_sel_q;
    issued_d   = issued_q;
    cast_d     = cast_q;
    cand_inc_d = 6'd0;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mode) begin
          state_d    = CLOSED;
          scan_sel_d = 3'd0;
          dwell_d    = '0;
        end else if (bus.issue) begin
          state_d  = ARMED;
          timer_d  = '0;
          issued_d = (issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
        end
      end
      ARMED: begin
        // Closing the poll voids the ballot even if a vote lands the same cycle.
        if (bus.mode) begin
          state_d    = CLOSED;
          scan_sel_d = 3'd0;
          dwell_d    = '0;
        end else if (vote_single) begin
          state_d    = CONFIRM;
          conf_cnt_d = '0;
          cand_inc_d = bus.vote_valid;
          cast_d     = (cast_q == 8'hFF) ? cast_q : cast_q + 8'd1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d  = timer_q + TW'(1);
          reject_d = vote_multi;
        end
      end
      CONFIRM: begin
        if (conf_cnt_q == CW'(CONFIRM_CYCLES - 1)) begin
          if (bus.mode) begin
            state_d    = CLOSED;
            scan_sel_d = 3'd0;
            dwell_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          conf_cnt_d = conf_cnt_q + CW'(1);
        end
      end
      CLOSED: begin
        if (!bus.mode) begin
          state_d    = IDLE;
          scan_sel_d = 3'd0;
          dwell_d    = '0;
        end else if (dwell_q == DW'(SCAN_DWELL - 1)) begin
          dwell_d    = '0;
          scan_sel_d = (scan_sel_q == 3'd5) ? 3'd0 : scan_sel_q + 3'd1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Level indications follow the next state so they line up with it.
    ballot_ready_d = (state_d == ARMED);
    confirm_d      = (state_d == CONFIRM);
    scan_valid_d   = (state_d == CLOSED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      conf_cnt_q     <= '0;
      dwell_q        <= '0;
      scan_sel_q     <= 3'd0;
      issued_q       <= 8'd0;
      cast_q         <= 8'd0;
      cand_inc_q     <= 6'd0;
      ballot_ready_q <= 1'b0;
      confirm_q      <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
      scan_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      conf_cnt_q     <= conf_cnt_d;
      dwell_q        <= dwell_d;
      scan_sel_q     <= scan_sel_d;
      issued_q       <= issued_d;
      cast_q         <= cast_d;
      cand_inc_q     <= cand_inc_d;
      ballot_ready_q <= ballot_ready_d;
      confirm_q      <= confirm_d;
      reject_q       <= reject_d;
      timeout_q      <= timeout_d;
      scan_valid_q   <= scan_valid_d;
    end
  end

  assign bus.cand_inc       = cand_inc_q;
  assign bus.ballot_ready   = ballot_ready_q;
  assign bus.confirm        = confirm_q;
  assign bus.reject         = reject_q;
  assign bus.timeout        = timeout_q;
  assign bus.ballots_issued = issued_q;
  assign bus.ballots_cast   = cast_q;
  assign bus.scan_sel       = scan_sel_q;
  assign bus.scan_valid     = scan_valid_q;

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Directed bench for ballot_session_ctrl with default timing parameters.
module tb_ballot_session_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ballot_session_ctrl_if bus();

  ballot_session_ctrl #(
    .TIMEOUT_CYCLES(1000), .CONFIRM_CYCLES(10), .SCAN_DWELL(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // {cand_inc, ready, confirm, reject, timeout, scan_valid, scan_sel}
  logic [13:0] obs;
  assign obs = {bus.cand_inc, bus.ballot_ready, bus.confirm, bus.reject,
                bus.timeout, bus.scan_valid, bus.scan_sel};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.mode = 1'b0; bus.issue = 1'b1; bus.vote_valid = 6'b111111;
    step(); step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL reset_outs got=%b exp=%b", obs, 14'd0); end
    checks++;
    if ({bus.ballots_issued, bus.ballots_cast} !== 16'd0) begin
      failures++; $display("FAIL reset_counts got=%h exp=0000", {bus.ballots_issued, bus.ballots_cast});
    end
    reset = 1'b0; bus.issue = 1'b0; bus.vote_valid = 6'd0;
    step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL idle_after_reset got=%b exp=%b", obs, 14'd0); end
  endtask

  task automatic test_single_vote();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    checks++;
    if (obs !== {6'd0, 5'b10000, 3'd0} || bus.ballots_issued !== 8'd1) begin
      failures++; $display("FAIL arm got=%b/%0d exp=%b/1", obs, bus.ballots_issued, {6'd0, 5'b10000, 3'd0});
    end
    step(); step();
    bus.vote_valid = 6'b000100; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== {6'b000100, 5'b01000, 3'd0} || bus.ballots_cast !== 8'd1) begin
      failures++; $display("FAIL accept got=%b/%0d exp=%b/1", obs, bus.ballots_cast, {6'b000100, 5'b01000, 3'd0});
    end
    for (int i = 1; i < 10; i++) begin
      step();
      checks++;
      if (obs !== {6'd0, 5'b01000, 3'd0}) begin
        failures++; $display("FAIL confirm_hold[%0d] got=%b exp=%b", i, obs, {6'd0, 5'b01000, 3'd0});
      end
    end
    step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL confirm_end got=%b exp=%b", obs, 14'd0); end
  endtask

  task automatic test_reject();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    bus.vote_valid = 6'b000011; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== {6'd0, 5'b10100, 3'd0}) begin
      failures++; $display("FAIL reject_pulse got=%b exp=%b", obs, {6'd0, 5'b10100, 3'd0});
    end
    step();
    checks++;
    if (obs !== {6'd0, 5'b10000, 3'd0}) begin
      failures++; $display("FAIL reject_single got=%b exp=%b", obs, {6'd0, 5'b10000, 3'd0});
    end
    bus.vote_valid = 6'b100000; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== {6'b100000, 5'b01000, 3'd0} || bus.ballots_cast !== 8'd2) begin
      failures++; $display("FAIL after_reject got=%b/%0d exp=%b/2", obs, bus.ballots_cast, {6'b100000, 5'b01000, 3'd0});
    end
    repeat (10) step();
  endtask

  task automatic test_timeout();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    repeat (999) step();
    checks++;
    if (obs !== {6'd0, 5'b10000, 3'd0}) begin
      failures++; $display("FAIL pre_timeout got=%b exp=%b", obs, {6'd0, 5'b10000, 3'd0});
    end
    step();
    checks++;
    if (obs !== {6'd0, 5'b00010, 3'd0} || bus.ballots_cast !== 8'd2) begin
      failures++; $display("FAIL timeout_pulse got=%b/%0d exp=%b/2", obs, bus.ballots_cast, {6'd0, 5'b00010, 3'd0});
    end
    bus.vote_valid = 6'b000001; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== 14'd0 || bus.ballots_cast !== 8'd2) begin
      failures++; $display("FAIL vote_after_timeout got=%b/%0d exp=%b/2", obs, bus.ballots_cast, 14'd0);
    end
  endtask

  task automatic test_vote_at_expiry();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    repeat (999) step();
    bus.vote_valid = 6'b010000; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== {6'b010000, 5'b01000, 3'd0} || bus.ballots_cast !== 8'd3) begin
      failures++; $display("FAIL expiry_vote got=%b/%0d exp=%b/3", obs, bus.ballots_cast, {6'b010000, 5'b01000, 3'd0});
    end
    repeat (10) step();
  endtask

  task automatic test_closed_scan();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    bus.mode = 1'b1; bus.vote_valid = 6'b000001; step(); bus.vote_valid = 6'd0;
    checks++;
    if (obs !== {6'd0, 5'b00001, 3'd0} || bus.ballots_cast !== 8'd3 || bus.ballots_issued !== 8'd5) begin
      failures++; $display("FAIL void_close got=%b/%0d/%0d exp=%b/3/5", obs, bus.ballots_cast,
                           bus.ballots_issued, {6'd0, 5'b00001, 3'd0});
    end
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] cur, nxt;
      cur = 3'(k - 1);
      nxt = 3'(k % 6);
      repeat (99) step();
      checks++;
      if (obs !== {6'd0, 5'b00001, cur}) begin
        failures++; $display("FAIL scan_dwell[%0d] got=%b exp=%b", k, obs, {6'd0, 5'b00001, cur});
      end
      step();
      checks++;
      if (obs !== {6'd0, 5'b00001, nxt}) begin
        failures++; $display("FAIL scan_step[%0d] got=%b exp=%b", k, obs, {6'd0, 5'b00001, nxt});
      end
    end
    bus.issue = 1'b1; bus.mode = 1'b0; step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL reopen got=%b exp=%b", obs, 14'd0); end
    step(); bus.issue = 1'b0;
    checks++;
    if (obs !== {6'd0, 5'b10000, 3'd0} || bus.ballots_issued !== 8'd6) begin
      failures++; $display("FAIL rearm_after_close got=%b/%0d exp=%b/6", obs, bus.ballots_issued, {6'd0, 5'b10000, 3'd0});
    end
    bus.vote_valid = 6'b001000; step(); bus.vote_valid = 6'd0;
    repeat (10) step();
  endtask

  task automatic test_back_to_back();
    bus.issue = 1'b1; step();
    bus.vote_valid = 6'b000010; step(); bus.vote_valid = 6'd0;
    repeat (9) step();
    step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", obs, 14'd0); end
    step(); bus.issue = 1'b0;
    checks++;
    if (obs !== {6'd0, 5'b10000, 3'd0} || bus.ballots_issued !== 8'd8) begin
      failures++; $display("FAIL b2b_rearm got=%b/%0d exp=%b/8", obs, bus.ballots_issued, {6'd0, 5'b10000, 3'd0});
    end
    bus.vote_valid = 6'b000001; step(); bus.vote_valid = 6'd0;
    bus.mode = 1'b1;
    repeat (9) step();
    checks++;
    if (obs !== {6'd0, 5'b01000, 3'd0}) begin
      failures++; $display("FAIL confirm_ignores_mode got=%b exp=%b", obs, {6'd0, 5'b01000, 3'd0});
    end
    step();
    checks++;
    if (obs !== {6'd0, 5'b00001, 3'd0} || bus.ballots_cast !== 8'd6) begin
      failures++; $display("FAIL confirm_to_closed got=%b/%0d exp=%b/6", obs, bus.ballots_cast, {6'd0, 5'b00001, 3'd0});
    end
    bus.mode = 1'b0; step();
  endtask

  task automatic test_reset_mid_confirm();
    bus.issue = 1'b1; step(); bus.issue = 1'b0;
    bus.vote_valid = 6'b000100; step(); bus.vote_valid = 6'd0;
    step();
    reset = 1'b1; step();
    checks++;
    if (obs !== 14'd0 || {bus.ballots_issued, bus.ballots_cast} !== 16'd0) begin
      failures++; $display("FAIL reset_mid_confirm got=%b/%h exp=%b/0000", obs,
                           {bus.ballots_issued, bus.ballots_cast}, 14'd0);
    end
    reset = 1'b0; step();
    checks++;
    if (obs !== 14'd0) begin failures++; $display("FAIL post_reset_idle got=%b exp=%b", obs, 14'd0); end
  endtask

  task automatic test_saturation();
    bus.issue = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int w;
      w = 0;
      while (!bus.ballot_ready && w < 50) begin step(); w++; end
      if (w >= 50) begin
        checks++; failures++;
        $display("FAIL sat_wait ballot %0d got=ready0 exp=ready1", n);
        break;
      end
      bus.vote_valid = 6'b000001; step(); bus.vote_valid = 6'd0;
    end
    bus.issue = 1'b0;
    checks++;
    if (bus.ballots_issued !== 8'd255 || bus.ballots_cast !== 8'd255) begin
      failures++; $display("FAIL saturate got=%0d/%0d exp=255/255", bus.ballots_issued, bus.ballots_cast);
    end
    repeat (12) step();
  endtask

  initial begin
    bus.mode = 1'b0; bus.issue = 1'b0; bus.vote_valid = 6'd0;
    test_reset();
    test_single_vote();
    test_reject();
    test_timeout();
    test_vote_at_expiry();
    test_closed_scan();
    test_back_to_back();
    test_reset_mid_confirm();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
